gaussian_5x5_filter: RTL
========================

# gaussian_5x5_filter

Pipelined 5×5 Gaussian smoothing stage that sits directly downstream of the 5-line window buffer (`Line_Buffer_Kernel_5`-style window source). Each cycle it accepts one 25-tap window, computes the separable 1-4-6-4-1 ⊗ 1-4-6-4-1 weighted sum, and emits a rounded output pixel. Column and row counters suppress windows that straddle a line wrap or fall in the top border. The block also pulses a frame-done flag after the last interior pixel.

## Interface
- `IMG_Width`, default 5: pixels per line; legal range ≥5.
- `IMG_Height`, default 5: lines per frame; legal range ≥5.
- `Datawidth`, default 8: pixel width in bits.
- `FIRST_COL`, default 4: column index of the newest pixel in the first window accepted after reset.
- `CLK`  in  1: sole clock; all state changes on the rising edge.
- `CLR`  in  1: asynchronous, active-high reset.
- `R00..R44`  in  Datawidth each: window taps. Row 0 is the oldest line, row 4 the newest. Column 0 is the oldest pixel and column 4 the newest.
- `Valid_IN`  in  1: window taps are valid this cycle.
- `Pixel_Out`  out  Datawidth: filtered pixel.
- `Valid_OUT`  out  1: `Pixel_Out` is a new interior result this cycle.
- `Frame_Done`  out  1: one-cycle pulse coincident with the last interior output of a frame.

## Operation
- Stage 1 (horizontal):
  - For each row r: `H[r] = Rr0 + 4·Rr1 + 6·Rr2 + 4·Rr3 + Rr4`.
  - Width is Datawidth+4; with the default Datawidth the maximum is 4080.
- Stage 2 (vertical):
  - `S = H0 + 4·H1 + 6·H2 + 4·H3 + H4`.
  - Width is Datawidth+8; with the default Datawidth the maximum is 65280.
- Stage 3 (normalize):
  - `Pixel_Out = (S + 2^7) >> 8`.
  - Saturate to 2^Datawidth−1. Saturation is unreachable for legal inputs but is required anyway.
  - All arithmetic is unsigned. Multiplications are implemented as shift-adds, with no DSP inference requirement.
- Column counter `col`:
  - Reset value is `FIRST_COL`.
  - Increments on every `Valid_IN` cycle and wraps from `IMG_Width−1` to 0.
  - When the counter wraps, `row` increments.
- Row counter `row`:
  - Reset value is 4.
  - From `IMG_Height−1` it wraps to 4, which is the start of the next frame's first full window.
- Interior test, sampled at stage 0: `interior = Valid_IN && col ≥ 4`.
  - A window with `col < 4` spans two lines. It is consumed (counters advance) but produces no `Valid_OUT`.
- Last-pixel test: `last = interior && col == IMG_Width−1 && row == IMG_Height−1`. Both flags are carried through the pipeline alongside the data.
- No back-pressure: the pipeline advances every cycle.
  - Gaps in `Valid_IN` insert bubbles.
  - Counters advance only on `Valid_IN`.
- `Pixel_Out` updates only when stage 3 is valid and holds otherwise.
- Interior outputs per frame: (IMG_Width−4)·(IMG_Height−4).

## Timing
- Latency is exactly 3 cycles: a window presented with `Valid_IN` in cycle t yields `Valid_OUT` and `Pixel_Out` in cycle t+3.
- Throughput is one window per cycle, sustained.
- All outputs are registered.
- Reset values: `Pixel_Out`=0, `Valid_OUT`=0, `Frame_Done`=0, `col`=`FIRST_COL`, `row`=4, valid/last pipeline flags=0.
- Reset asserted mid-operation:
  - All in-flight results are discarded immediately (asynchronous).
  - No `Valid_OUT` appears for windows accepted before or during reset.
  - The first window after `CLR` deasserts is treated as column `FIRST_COL`.
- `CLR` dominates `Valid_IN` in the same cycle.
- `Frame_Done` is high in the same cycle as the `Valid_OUT` that carries the last interior pixel. It is never high without `Valid_OUT`.
- When `col` and `row` wrap in the same cycle, both update on that edge; the next window is the new frame's column 0.

## Structure
- Shared package `gauss5_pkg` holds:
  - kernel weights (1, 4, 6) as constants;
  - normalization shift (8) and rounding constant (128);
  - width helper functions for stage 1 (Datawidth+4) and stage 2 (Datawidth+8).
- Sub-module `gauss_14641`:
  - parameterized input width;
  - combinational five-input weighted sum `a + 4b + 6c + 4d + e`.
  - Instanced five times in stage 1 and once in stage 2; the top level registers each stage output.
- Counters, interior/last logic and the 3-deep valid/last shift register live in the top level.

## Test plan
- Flat field: all 25 taps = 100, single `Valid_IN` at `col`=4 → `Pixel_Out`=100, `Valid_OUT`=1 exactly 3 cycles later.
- Impulses:
  - Center impulse: R22=255, all others 0 → `Pixel_Out`=36.
  - Corner impulse: R00=255 → 1.
  - All taps 255 → 255, with no overflow.
- Line masking: `IMG_Width`=8, `IMG_Height`=6, `FIRST_COL`=4, continuous `Valid_IN` for 8 windows.
  - 4 `Valid_OUT` pulses from the first 4 windows (cols 4–7).
  - The next 4 windows (cols 0–3) produce none.
- Frame completion: same parameters, stream a full frame of windows → 8 `Valid_OUT` total. `Frame_Done` pulses once with the 8th; `row` and `col` return to 4 and 0.
- Bubbles: `Valid_IN` toggled 1,0,1,0 with distinct windows → outputs 3 cycles after each accepted window, with `Pixel_Out` held during the gaps.
- Reset mid-pipeline: assert `CLR` one cycle after two valid windows → no `Valid_OUT` appears; after release the next window is treated as `col`=`FIRST_COL`.

Source files
------------

// File: rtl/gauss5_pkg.sv
// Shared constants and width helpers for the 5x5 Gaussian smoothing stage.
// Weights are the binomial 1-4-6-4-1 row; normalisation divides by 256 with rounding.
package gauss5_pkg;

    localparam int unsigned W_EDGE      = 1;
    localparam int unsigned W_NEAR      = 4;
    localparam int unsigned W_CENTER    = 6;
    localparam int unsigned NORM_SHIFT  = 8;
    localparam int unsigned ROUND_CONST = 128;

    // Horizontal pass sums 16x one pixel at most, so it grows by 4 bits.
    function automatic int h_width(input int dw);
        return dw + 4;
    endfunction

    // Vertical pass adds another factor of 16 on top of the horizontal sums.
    function automatic int s_width(input int dw);
        return dw + 8;
    endfunction

endpackage

// File: rtl/gauss_14641.sv
// Purpose: combinational binomial weighted sum a + 4b + 6c + 4d + e using shift-adds.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module gauss_14641 #(
    parameter int IW = 8,
    parameter int OW = IW + 4
) (
    input  logic [IW-1:0] a,
    input  logic [IW-1:0] b,
    input  logic [IW-1:0] c,
    input  logic [IW-1:0] d,
    input  logic [IW-1:0] e,
    output logic [OW-1:0] sum
);

    // 6c is formed as 4c + 2c so no multiplier is inferred.
    assign sum = OW'(a) + (OW'(b) << 2) + (OW'(c) << 2) + (OW'(c) << 1)
               + (OW'(d) << 2) + OW'(e);

endmodule

// File: rtl/gaussian_5x5_filter.sv
// Purpose: 5x5 separable Gaussian smoothing of a window stream with line-wrap masking and frame-done pulse.
// Latency: 3 cycles from Valid_IN to Valid_OUT/Pixel_Out, one window per cycle sustained.
// Backpressure: none; the pipeline advances every cycle, gaps in Valid_IN become bubbles.
module gaussian_5x5_filter
    import gauss5_pkg::*;
#(
    parameter int IMG_Width  = 5,
    parameter int IMG_Height = 5,
    parameter int Datawidth  = 8,
    parameter int FIRST_COL  = 4
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [Datawidth-1:0] R00, R01, R02, R03, R04,
    input  logic [Datawidth-1:0] R10, R11, R12, R13, R14,
    input  logic [Datawidth-1:0] R20, R21, R22, R23, R24,
    input  logic [Datawidth-1:0] R30, R31, R32, R33, R34,
    input  logic [Datawidth-1:0] R40, R41, R42, R43, R44,
    input  logic                 Valid_IN,
    output logic [Datawidth-1:0] Pixel_Out,
    output logic                 Valid_OUT,
    output logic                 Frame_Done
);

    localparam int HW = h_width(Datawidth);
    localparam int SW = s_width(Datawidth);
    localparam int CW = $clog2(IMG_Width);
    localparam int RW = $clog2(IMG_Height);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(FIRST_COL);
    localparam logic [CW-1:0] COL_FULL  = CW'(4);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 1);
    localparam logic [RW-1:0] ROW_START = RW'(4);

    logic [Datawidth-1:0] tap [5][5];

    assign tap[0][0] = R00; assign tap[0][1] = R01; assign tap[0][2] = R02; assign tap[0][3] = R03; assign tap[0][4] = R04;
    assign tap[1][0] = R10; assign tap[1][1] = R11; assign tap[1][2] = R12; assign tap[1][3] = R13; assign tap[1][4] = R14;
    assign tap[2][0] = R20; assign tap[2][1] = R21; assign tap[2][2] = R22; assign tap[2][3] = R23; assign tap[2][4] = R24;
    assign tap[3][0] = R30; assign tap[3][1] = R31; assign tap[3][2] = R32; assign tap[3][3] = R33; assign tap[3][4] = R34;
    assign tap[4][0] = R40; assign tap[4][1] = R41; assign tap[4][2] = R42; assign tap[4][3] = R43; assign tap[4][4] = R44;

    logic [HW-1:0]        h_d [5];
    logic [HW-1:0]        h_q [5];
    logic [SW-1:0]        s_d, s_q;
    logic [Datawidth-1:0] pix_d, pix_q;
    logic [SW:0]          rnd;
    logic [Datawidth:0]   pix_pre;
    logic [CW-1:0]        col_d, col_q;
    logic [RW-1:0]        row_d, row_q;
    logic                 interior, last;
    logic                 v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;

    for (genvar r = 0; r < 5; r++) begin : g_hpass
        gauss_14641 #(.IW(Datawidth), .OW(HW)) u_h (
            .a(tap[r][0]), .b(tap[r][1]), .c(tap[r][2]), .d(tap[r][3]), .e(tap[r][4]),
            .sum(h_d[r])
        );
    end

    gauss_14641 #(.IW(HW), .OW(SW)) u_v (
        .a(h_q[0]), .b(h_q[1]), .c(h_q[2]), .d(h_q[3]), .e(h_q[4]),
        .sum(s_d)
    );

    // Windows with the newest pixel in columns 0..3 still contain the previous line's tail.
    assign interior = Valid_IN && (col_q >= COL_FULL);
    assign last     = interior && (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (Valid_IN) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? ROW_START : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Saturation cannot trigger for in-range taps but keeps the output well defined.
    always_comb begin
        rnd     = {1'b0, s_q} + (SW+1)'(ROUND_CONST);
        pix_pre = (Datawidth+1)'(rnd >> NORM_SHIFT);
        pix_d   = pix_q;
        if (v2_q) begin
            pix_d = pix_pre[Datawidth] ? '1 : pix_pre[Datawidth-1:0];
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int r = 0; r < 5; r++) h_q[r] <= '0;
            s_q   <= '0;
            pix_q <= '0;
            col_q <= COL_FIRST;
            row_q <= ROW_START;
            v1_q  <= 1'b0;
            l1_q  <= 1'b0;
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            v3_q  <= 1'b0;
            l3_q  <= 1'b0;
        end else begin
            for (int r = 0; r < 5; r++) h_q[r] <= h_d[r];
            s_q   <= s_d;
            pix_q <= pix_d;
            col_q <= col_d;
            row_q <= row_d;
            v1_q  <= interior;
            l1_q  <= last;
            v2_q  <= v1_q;
            l2_q  <= l1_q;
            v3_q  <= v2_q;
            l3_q  <= l2_q;
        end
    end

    assign Pixel_Out  = pix_q;
    assign Valid_OUT  = v3_q;
    assign Frame_Done = l3_q;

endmodule
